fpu_io_result_tx: RTL and testbench

FPU_IO_RESULT_TX -- requirements
Module: fpu_io_result_tx

---
 rtl/fpu_io_result_tx_if.sv | 17 +
 rtl/fpu_io_result_tx.sv | 181 ++++++++++++++++++
 tb/tb_fpu_io_result_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_io_result_tx_if.sv
// fpu_io_result_tx_if
// Result handshake between the FPU and the pad transmitter.
//   res_valid_i  FPU offers a result this cycle
//   res_ready_o  transmitter FIFO can take it (transfer on valid && ready)
//   res_data_i   32-bit result word
//   res_flags_i  IEEE exception flags {NV,DZ,OF,UF,NX}
// The signal names keep the transmitter-side direction suffixes so they
// read the same at both ends of the connection.
interface fpu_io_result_tx_if;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [31:0] res_data_i;
  logic [4:0]  res_flags_i;

  modport master (output res_valid_i, res_data_i, res_flags_i, input res_ready_o);
  modport slave  (input res_valid_i, res_data_i, res_flags_i, output res_ready_o);
endinterface

// File: rtl/fpu_io_result_tx.sv
// fpu_io_result_tx
// Buffers FPU results in a small FIFO and serialises each one onto the IO pads
// as a frame: data word for H cycles, a tagged flags word for H cycles, then
// one zero gap cycle.
// Ports:
//   wb_clk_i       clock, all state on rising edge
//   wb_rst_ni      asynchronous active-low reset
//   enable_i       1 = drive pads and run; 0 = pads tristated, FSM parked
//   hold_cycles_i  cycles per phase, sampled at frame start (0 acts as 1)
//   res            result handshake (slave side)
//   io_out         registered pad value
//   io_oeb         pad output-enable-bar, one per bit
//   busy_o         frame in progress or FIFO not empty
//   seq_o          count of frames completed, wraps at 255
//
// state   | meaning
// S_IDLE  | parked, pads at zero, waiting for enable and a queued result
// S_DATA  | result data word on pads
// S_FLAGS | {8'hA5, seq, 11'b0, flags} on pads
// S_GAP   | one zero cycle separating frames
module fpu_io_result_tx #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              enable_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  fpu_io_result_tx_if.slave res,
  output logic [31:0]       io_out,
  output logic [31:0]       io_oeb,
  output logic              busy_o,
  output logic [7:0]        seq_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FLAGS, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic              run;
  logic [36:0]       mem [DEPTH];
  logic [36:0]       head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop;
  logic [HOLD_W-1:0] hold_q, hold_d, cnt_q, cnt_d, h_eff;
  logic [4:0]        flags_q, flags_d;
  logic [31:0]       io_d;
  logic [7:0]        seq_d;

  // Reset release is re-timed so the FSM only starts two clean edges later.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) sync_q <= 2'b00;
    else            sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  // A full FIFO still accepts when the head is leaving the same cycle.
  assign res.res_ready_o = !full || pop;
  assign push  = res.res_valid_i && res.res_ready_o;

  assign h_eff  = (hold_cycles_i == '0) ? HOLD_W'(1) : hold_cycles_i;
  assign io_oeb = enable_i ? 32'h0000_0000 : 32'hFFFF_FFFF;
  assign busy_o = (state_q != S_IDLE) || !empty;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= {res.res_flags_i, res.res_data_i};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    flags_d = flags_q;
    io_d    = io_out;
    seq_d   = seq_o;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        io_d = 32'h0;
        if (enable_i && run && !empty) begin
          pop     = 1'b1;
          state_d = S_DATA;
          hold_d  = h_eff;
          cnt_d   = h_eff - HOLD_W'(1);
          flags_d = head[36:32];
          io_d    = head[31:0];
        end
      end
      S_DATA: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          io_d    = 32'h0;
        end else if (cnt_q == '0) begin
          state_d = S_FLAGS;
          cnt_d   = hold_q - HOLD_W'(1);
          io_d    = {8'hA5, seq_o, 11'b0, flags_q};
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      S_FLAGS: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          io_d    = 32'h0;
        end else if (cnt_q == '0) begin
          state_d = S_GAP;
          io_d    = 32'h0;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      S_GAP: begin
        io_d = 32'h0;
        if (!enable_i) begin
          // Aborted frames never count, even when only the gap was left.
          state_d = S_IDLE;
        end else begin
          seq_d = seq_o + 8'd1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_DATA;
            hold_d  = h_eff;
            cnt_d   = h_eff - HOLD_W'(1);
            flags_d = head[36:32];
            io_d    = head[31:0];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        io_d    = 32'h0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      flags_q <= '0;
      io_out  <= 32'h0;
      seq_o   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      flags_q <= flags_d;
      io_out  <= io_d;
      seq_o   <= seq_d;
    end
  end

endmodule

// File: tb/tb_fpu_io_result_tx.sv
module tb_fpu_io_result_tx;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [15:0] hold_cycles_i = 16'd0;
  logic [31:0] io_out, io_oeb;
  logic        busy_o;
  logic [7:0]  seq_o;

  fpu_io_result_tx_if bus();

  fpu_io_result_tx #(.DEPTH(4), .HOLD_W(16)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_ni     (wb_rst_ni),
    .enable_i      (enable_i),
    .hold_cycles_i (hold_cycles_i),
    .res           (bus.slave),
    .io_out        (io_out),
    .io_oeb        (io_oeb),
    .busy_o        (busy_o),
    .seq_o         (seq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] val;
    bit          first;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_seq = 8'd0;
  bit         stalled = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Expected pad sequence for one frame; limit >= 0 keeps only the first
  // entries (frame that gets aborted, so seq does not advance).
  task automatic exp_frame(input logic [31:0] d, input logic [4:0] f, input int h, input int limit);
    logic [31:0] fw;
    int he, n;
    exp_t e;
    he = (h == 0) ? 1 : h;
    n  = 0;
    fw = {8'hA5, exp_seq, 11'b0, f};
    for (int i = 0; i < he; i++) begin
      e.val = d; e.first = (i == 0);
      if (limit < 0 || n < limit) exp_q.push_back(e);
      n++;
    end
    for (int i = 0; i < he; i++) begin
      e.val = fw; e.first = 1'b0;
      if (limit < 0 || n < limit) exp_q.push_back(e);
      n++;
    end
    e.val = 32'h0; e.first = 1'b0;
    if (limit < 0 || n < limit) exp_q.push_back(e);
    if (limit < 0) exp_seq = exp_seq + 8'd1;
  endtask

  // Called at a falling edge; returns at a later falling edge after the transfer.
  task automatic push_res(input logic [31:0] d, input logic [4:0] f);
    int g;
    g = 0;
    bus.res_valid_i = 1'b1;
    bus.res_data_i  = d;
    bus.res_flags_i = f;
    #1;
    while (bus.res_ready_o !== 1'b1 && g < 2000) begin
      stalled = 1'b1;
      @(negedge wb_clk_i);
      #1;
      g++;
    end
    if (g >= 2000) timeout_fail("push_ready");
    @(negedge wb_clk_i);
    bus.res_valid_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] f);
    exp_frame(d, f, int'(hold_cycles_i), -1);
    push_res(d, f);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    do begin
      @(negedge wb_clk_i);
      g++;
    end while ((exp_q.size() != 0 || busy_o) && g < 5000);
    if (g >= 5000) timeout_fail(name);
  endtask

  task automatic wait_io(input logic [31:0] v, input string name);
    int g;
    g = 0;
    while (io_out !== v && g < 500) begin
      @(negedge wb_clk_i);
      g++;
    end
    if (g >= 500) timeout_fail(name);
  endtask

  // Monitor: each falling edge, compare pads against the scoreboard head.
  // Zeros before a frame's first word are idle cycles and are skipped.
  initial begin
    int idle_wait;
    idle_wait = 0;
    forever begin
      @(negedge wb_clk_i);
      if (exp_q.size() != 0) begin
        if (exp_q[0].first && io_out == 32'h0) begin
          idle_wait++;
          if (idle_wait > 300) begin
            timeout_fail("frame_start");
            exp_q.delete();
            idle_wait = 0;
          end
        end else begin
          idle_wait = 0;
          check32("io_out", io_out, exp_q[0].val);
          void'(exp_q.pop_front());
        end
      end else begin
        idle_wait = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] f2w;
    bus.res_valid_i = 1'b0;
    bus.res_data_i  = 32'h0;
    bus.res_flags_i = 5'h0;

    // Reset state
    #12;
    check32("rst_io_out", io_out, 32'h0);
    check32("rst_seq", {24'h0, seq_o}, 32'h0);
    check32("rst_ready", {31'h0, bus.res_ready_o}, 32'h1);
    check32("rst_busy", {31'h0, busy_o}, 32'h0);
    check32("rst_oeb", io_oeb, 32'hFFFF_FFFF);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    repeat (3) @(negedge wb_clk_i);

    // Single frame, hold 3
    enable_i = 1'b1;
    hold_cycles_i = 16'd3;
    #1;
    check32("oeb_enabled", io_oeb, 32'h0);
    @(negedge wb_clk_i);
    send(32'h3F80_0000, 5'h00);
    drain("drain_single");
    check32("seq_single", {24'h0, seq_o}, 32'd1);
    check32("busy_single", {31'h0, busy_o}, 32'h0);

    // Hold 0 behaves as 1
    hold_cycles_i = 16'd0;
    send(32'h0000_0003, 5'h01);
    drain("drain_hold0");
    check32("seq_hold0", {24'h0, seq_o}, 32'd2);

    // Six back-to-back results, FIFO fills and back-pressures
    hold_cycles_i = 16'd4;
    stalled = 1'b0;
    for (int i = 0; i < 6; i++) send(32'h1000_0001 + 32'(i), 5'(i + 3));
    drain("drain_burst");
    check32("burst_stalled", {31'h0, stalled}, 32'h1);
    check32("seq_burst", {24'h0, seq_o}, 32'd8);

    // Enable dropped during the flags phase of frame 2
    hold_cycles_i = 16'd2;
    send(32'h2000_0001, 5'h11);
    exp_frame(32'h2000_0002, 5'h12, 2, 3);
    push_res(32'h2000_0002, 5'h12);
    push_res(32'h2000_0003, 5'h13);
    f2w = {8'hA5, 8'd9, 11'b0, 5'h12};
    wait_io(f2w, "wait_flags2");
    enable_i = 1'b0;
    #1;
    check32("abort_oeb", io_oeb, 32'hFFFF_FFFF);
    @(negedge wb_clk_i);
    check32("abort_io_out", io_out, 32'h0);
    check32("abort_seq", {24'h0, seq_o}, 32'd9);
    repeat (3) @(negedge wb_clk_i);
    check32("abort_kept", {31'h0, busy_o}, 32'h1);
    exp_frame(32'h2000_0003, 5'h13, 2, -1);
    enable_i = 1'b1;
    drain("drain_resume");
    check32("seq_resume", {24'h0, seq_o}, 32'd10);

    // Reset pulse mid-DATA with results queued
    hold_cycles_i = 16'd4;
    exp_frame(32'h3000_0001, 5'h01, 4, 1);
    push_res(32'h3000_0001, 5'h01);
    push_res(32'h3000_0002, 5'h02);
    push_res(32'h3000_0003, 5'h03);
    push_res(32'h3000_0004, 5'h04);
    wait_io(32'h3000_0001, "wait_rst_data");
    check32("pre_rst_busy", {31'h0, busy_o}, 32'h1);
    wb_rst_ni = 1'b0;
    #1;
    check32("mid_rst_io_out", io_out, 32'h0);
    check32("mid_rst_seq", {24'h0, seq_o}, 32'h0);
    check32("mid_rst_ready", {31'h0, bus.res_ready_o}, 32'h1);
    check32("mid_rst_busy", {31'h0, busy_o}, 32'h0);
    exp_q.delete();
    exp_seq = 8'd0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    repeat (10) @(negedge wb_clk_i);
    check32("post_rst_busy", {31'h0, busy_o}, 32'h0);
    check32("post_rst_io_out", io_out, 32'h0);

    // 256 frames, sequence wraps
    hold_cycles_i = 16'd0;
    for (int i = 0; i < 256; i++) send(32'h0100_0000 + 32'(i), 5'(i));
    drain("drain_wrap");
    check32("seq_wrap", {24'h0, seq_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
